// File: rtl/sa_stream_engine_if.sv
// Operand/result bus for sa_stream_engine: control, operand beat handshake and result handshake.
// Optional SA_SAT_FLAG_EN adds O_SAT_FLAG.
interface sa_stream_engine_if #(
  parameter int D_W   = 16,
  parameter int SA_R  = 16,
  parameter int SA_C  = 16,
  parameter int K_MAX = 256
);
  localparam int KW = $clog2(K_MAX + 1);

  logic                                 I_START;
  logic [KW-1:0]                        I_K;
  logic                                 I_ACC_MODE;
  logic                                 I_IN_VLD;
  logic                                 O_IN_RDY;
  logic [0:SA_R-1][D_W-1:0]             I_X_VEC;
  logic [0:SA_C-1][D_W-1:0]             I_W_VEC;
  logic                                 O_OUT_VLD;
  logic                                 I_OUT_RDY;
  logic [0:SA_R-1][0:SA_C-1][D_W-1:0]   O_OUT;
  logic                                 O_BUSY;
`ifdef SA_SAT_FLAG_EN
  logic                                 O_SAT_FLAG;
`endif

  modport master (
`ifdef SA_SAT_FLAG_EN
    input  O_SAT_FLAG,
`endif
    output I_START, I_K, I_ACC_MODE, I_IN_VLD, I_X_VEC, I_W_VEC, I_OUT_RDY,
    input  O_IN_RDY, O_OUT_VLD, O_OUT, O_BUSY
  );

  modport slave (
`ifdef SA_SAT_FLAG_EN
    output O_SAT_FLAG,
`endif
    input  I_START, I_K, I_ACC_MODE, I_IN_VLD, I_X_VEC, I_W_VEC, I_OUT_RDY,
    output O_IN_RDY, O_OUT_VLD, O_OUT, O_BUSY
  );
endinterface

// File: rtl/sa_stream_engine.sv
// Streamed OUT = X*W on an output-stationary SA_R x SA_C MAC array; result valid SA_R+SA_C cycles after the last beat,
// operand beats stall on O_IN_RDY, result held until I_OUT_RDY. Optional SA_SAT_FLAG_EN adds O_SAT_FLAG.
module sa_stream_engine #(
  parameter int D_W   = 16,
  parameter int FRAC  = 13,
  parameter int SA_R  = 16,
  parameter int SA_C  = 16,
  parameter int K_MAX = 256,
  parameter int ACC_W = 32
) (
  input  logic              I_CLK,
  input  logic              I_SYNC_RST,
  sa_stream_engine_if.slave bus
);
  localparam int KW  = $clog2(K_MAX + 1);
  localparam int DCW = $clog2(SA_R + SA_C + 1);
  localparam int PW  = 2 * D_W - FRAC;
  localparam int PL  = SA_R + SA_C - 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (D_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - 1;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_e;

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d, beat_q, beat_d, k_start;
  logic [DCW-1:0]   drain_q, drain_d;
  logic             xfer, clr_acc, acc_en;

  logic [D_W-1:0]            xr_q [SA_R][PL];
  logic [D_W-1:0]            wc_q [SA_C][PL];
  logic signed [ACC_W-1:0]   acc_q [SA_R][SA_C];
  logic signed [2*D_W-1:0]   prod_full;
  logic signed [PW-1:0]      prod_sh [SA_R][SA_C];

  assign k_start = (bus.I_K > KW'(K_MAX)) ? KW'(K_MAX) : bus.I_K;

  always_ff @(posedge I_CLK) begin
    if (I_SYNC_RST) begin
      state_q <= IDLE;
      k_q     <= '0;
      beat_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      beat_q  <= beat_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    beat_d  = beat_q;
    drain_d = drain_q;
    clr_acc = 1'b0;
    xfer    = 1'b0;
    case (state_q)
      IDLE: if (bus.I_START) begin
        k_d     = k_start;
        beat_d  = '0;
        drain_d = '0;
        clr_acc = ~bus.I_ACC_MODE;
        state_d = (k_start == '0) ? DRAIN : LOAD;
      end
      LOAD: if (bus.I_IN_VLD) begin
        xfer   = 1'b1;
        beat_d = beat_q + KW'(1);
        if (beat_q == k_q - KW'(1)) begin
          state_d = DRAIN;
          drain_d = '0;
        end
      end
      // Counting through SA_R+SA_C edges lets the farthest PE absorb the last beat.
      DRAIN: if (drain_q == DCW'(SA_R + SA_C - 1)) state_d = DONE;
             else drain_d = drain_q + DCW'(1);
      DONE: if (bus.I_OUT_RDY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign acc_en        = (state_q == LOAD) || (state_q == DRAIN);
  assign bus.O_IN_RDY  = (state_q == LOAD);
  assign bus.O_OUT_VLD = (state_q == DONE);
  assign bus.O_BUSY    = (state_q != IDLE);

  // Position p of a row/column line holds the beat that entered p edges ago; PE(i,j) taps i+j.
  always_ff @(posedge I_CLK) begin
    if (I_SYNC_RST) begin
      for (int i = 0; i < SA_R; i++)
        for (int p = 0; p < PL; p++) xr_q[i][p] <= '0;
      for (int j = 0; j < SA_C; j++)
        for (int p = 0; p < PL; p++) wc_q[j][p] <= '0;
    end else begin
      for (int i = 0; i < SA_R; i++) begin
        xr_q[i][0] <= xfer ? bus.I_X_VEC[i] : '0;
        for (int p = 1; p < PL; p++) xr_q[i][p] <= xr_q[i][p-1];
      end
      for (int j = 0; j < SA_C; j++) begin
        wc_q[j][0] <= xfer ? bus.I_W_VEC[j] : '0;
        for (int p = 1; p < PL; p++) wc_q[j][p] <= wc_q[j][p-1];
      end
    end
  end

  always_comb begin
    prod_full = '0;
    prod_sh   = '{default: '0};
    for (int i = 0; i < SA_R; i++) begin
      for (int j = 0; j < SA_C; j++) begin
        prod_full     = $signed(xr_q[i][i+j]) * $signed(wc_q[j][i+j]);
        prod_sh[i][j] = PW'(prod_full >>> FRAC);
      end
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_SYNC_RST || clr_acc) begin
      for (int i = 0; i < SA_R; i++)
        for (int j = 0; j < SA_C; j++) acc_q[i][j] <= '0;
    end else if (acc_en) begin
      for (int i = 0; i < SA_R; i++)
        for (int j = 0; j < SA_C; j++) acc_q[i][j] <= acc_q[i][j] + ACC_W'(prod_sh[i][j]);
    end
  end

  always_comb begin
    bus.O_OUT = '0;
    for (int i = 0; i < SA_R; i++) begin
      for (int j = 0; j < SA_C; j++) begin
        if (acc_q[i][j] > SAT_MAX)      bus.O_OUT[i][j] = SAT_MAX[D_W-1:0];
        else if (acc_q[i][j] < SAT_MIN) bus.O_OUT[i][j] = SAT_MIN[D_W-1:0];
        else                            bus.O_OUT[i][j] = acc_q[i][j][D_W-1:0];
      end
    end
  end

`ifdef SA_SAT_FLAG_EN
  logic any_clip, sat_flag_q;

  always_comb begin
    any_clip = 1'b0;
    for (int i = 0; i < SA_R; i++)
      for (int j = 0; j < SA_C; j++)
        if ((acc_q[i][j] > SAT_MAX) || (acc_q[i][j] < SAT_MIN)) any_clip = 1'b1;
  end

  // Captured on entry to DONE, when the accumulators are final and frozen.
  always_ff @(posedge I_CLK) begin
    if (I_SYNC_RST)                                sat_flag_q <= 1'b0;
    else if (state_q == DRAIN && state_d == DONE)  sat_flag_q <= any_clip;
    else if (state_q == DONE && state_d == IDLE)   sat_flag_q <= 1'b0;
  end

  assign bus.O_SAT_FLAG = sat_flag_q;
`endif
endmodule

// File: tb/tb_sa_stream_engine.sv
// Self-checking bench for sa_stream_engine: table of runs with a result scoreboard, plus hold and mid-run reset sequences.
module tb_sa_stream_engine;
  localparam int D_W = 16, FRAC = 13, SA_R = 16, SA_C = 16, K_MAX = 256, ACC_W = 32;
  localparam int KW  = $clog2(K_MAX + 1);
  localparam int LAT = SA_R + SA_C;

  typedef struct {
    int          k_req;
    bit          acc;
    bit          ident;
    bit          bubble;
    logic [15:0] xv;
    logic [15:0] wv;
    logic [15:0] exp_out;
    bit          exp_sat;
  } vec_t;

  typedef struct packed {
    logic [15:0] val;
    logic        sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  vec_t vecs[11];

  always #5 clk = ~clk;

  sa_stream_engine_if #(.D_W(D_W), .SA_R(SA_R), .SA_C(SA_C), .K_MAX(K_MAX)) bus ();

  sa_stream_engine #(
    .D_W(D_W), .FRAC(FRAC), .SA_R(SA_R), .SA_C(SA_C), .K_MAX(K_MAX), .ACC_W(ACC_W)
  ) dut (
    .I_CLK(clk),
    .I_SYNC_RST(rst),
    .bus(bus)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic chk_out_all(input string name, input logic [15:0] exp);
    int bad = 0;
    logic [15:0] first_got = '0;
    for (int i = 0; i < SA_R; i++)
      for (int j = 0; j < SA_C; j++)
        if (bus.O_OUT[i][j] !== exp) begin
          if (bad == 0) first_got = bus.O_OUT[i][j];
          bad++;
        end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (%0d elements differ)", name, first_got, exp, bad);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input bit ident, input int b, input logic [15:0] xv, input logic [15:0] wv);
    for (int i = 0; i < SA_R; i++) bus.I_X_VEC[i] = ident ? ((i == b) ? xv : 16'h0000) : xv;
    for (int j = 0; j < SA_C; j++) bus.I_W_VEC[j] = wv;
  endtask

  task automatic start_run(input int k_req, input bit acc);
    bus.I_START    = 1'b1;
    bus.I_K        = KW'(k_req);
    bus.I_ACC_MODE = acc;
    tick();
    bus.I_START    = 1'b0;
  endtask

  // Feeds kb beats, then counts edges from the last accepting edge (or start edge when kb==0) to O_OUT_VLD.
  task automatic feed(input string name, input bit ident, input bit bubble, input logic [15:0] xv,
                      input logic [15:0] wv, input int kb, output int lat);
    int  b = 0;
    int  cyc = 0;
    bit  acc_beat;
    while (b < kb && cyc < 2000) begin
      bus.I_IN_VLD = bubble ? (cyc % 2 == 1) : 1'b1;
      set_beat(ident, b, xv, wv);
      acc_beat = bus.I_IN_VLD && bus.O_IN_RDY;
      tick();
      cyc++;
      if (acc_beat) b++;
    end
    bus.I_IN_VLD = 1'b0;
    set_beat(1'b0, 0, 16'h0000, 16'h0000);
    if (b < kb) chk({name, "_beats"}, b, kb);
    lat = 0;
    while (!bus.O_OUT_VLD && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic collect(input string name);
    exp_t e;
    chk({name, "_vld"}, bus.O_OUT_VLD, 1'b1);
    if (bus.O_OUT_VLD && sb.size() > 0) begin
      e = sb.pop_front();
      chk_out_all({name, "_out"}, e.val);
`ifdef SA_SAT_FLAG_EN
      chk({name, "_sat"}, bus.O_SAT_FLAG, e.sat);
`endif
    end
    bus.I_OUT_RDY = 1'b1;
    tick();
    bus.I_OUT_RDY = 1'b0;
    chk({name, "_vld_after"}, bus.O_OUT_VLD, 1'b0);
    chk({name, "_busy_after"}, bus.O_BUSY, 1'b0);
  endtask

  task automatic full_run(input string name, input vec_t v);
    int kb;
    int lat;
    kb = (v.k_req > K_MAX) ? K_MAX : v.k_req;
    sb.push_back({v.exp_out, v.exp_sat});
    start_run(v.k_req, v.acc);
    feed(name, v.ident, v.bubble, v.xv, v.wv, kb, lat);
    chk({name, "_lat"}, lat, LAT);
    collect(name);
  endtask

  initial begin
    int lat;
    // {k_req, acc, ident, bubble, x, w, expected OUT, expected clip}
    vecs[0]  = '{16,  1'b0, 1'b1, 1'b0, 16'h2000, 16'h1000, 16'h1000, 1'b0};
    vecs[1]  = '{4,   1'b0, 1'b0, 1'b0, 16'h6000, 16'h6000, 16'h7FFF, 1'b1};
    vecs[2]  = '{4,   1'b0, 1'b0, 1'b0, 16'h6000, 16'hA000, 16'h8000, 1'b1};
    vecs[3]  = '{8,   1'b0, 1'b0, 1'b1, 16'h0800, 16'h0800, 16'h1000, 1'b0};
    vecs[4]  = '{8,   1'b0, 1'b0, 1'b0, 16'h0800, 16'h0800, 16'h1000, 1'b0};
    vecs[5]  = '{4,   1'b0, 1'b0, 1'b0, 16'h1000, 16'h1000, 16'h2000, 1'b0};
    vecs[6]  = '{4,   1'b1, 1'b0, 1'b0, 16'h1000, 16'h1000, 16'h4000, 1'b0};
    vecs[7]  = '{4,   1'b0, 1'b0, 1'b0, 16'h1000, 16'h1000, 16'h2000, 1'b0};
    vecs[8]  = '{3,   1'b0, 1'b0, 1'b0, 16'h0001, 16'hFFFF, 16'hFFFD, 1'b0};
    vecs[9]  = '{0,   1'b0, 1'b0, 1'b0, 16'h2000, 16'h2000, 16'h0000, 1'b0};
    vecs[10] = '{300, 1'b0, 1'b0, 1'b0, 16'h2000, 16'h0010, 16'h1000, 1'b0};

    rst = 1'b1;
    bus.I_START = 1'b0;
    bus.I_K = '0;
    bus.I_ACC_MODE = 1'b0;
    bus.I_IN_VLD = 1'b0;
    bus.I_OUT_RDY = 1'b0;
    set_beat(1'b0, 0, 16'h0000, 16'h0000);
    tick();
    tick();
    chk("rst_in_rdy", bus.O_IN_RDY, 1'b0);
    chk("rst_out_vld", bus.O_OUT_VLD, 1'b0);
    chk("rst_busy", bus.O_BUSY, 1'b0);
    chk_out_all("rst_out", 16'h0000);
    rst = 1'b0;
    tick();

    for (int n = 0; n < 11; n++) full_run($sformatf("v%0d", n), vecs[n]);

    // Result held in DONE while I_OUT_RDY is low; a start pulse there is ignored.
    sb.push_back({16'h2000, 1'b0});
    start_run(4, 1'b0);
    feed("hold", 1'b0, 1'b0, 16'h1000, 16'h1000, 4, lat);
    chk("hold_lat", lat, LAT);
    for (int c = 0; c < 10; c++) begin
      bus.I_START = (c == 3);
      bus.I_K = KW'(5);
      tick();
      chk_out_all($sformatf("hold_out_c%0d", c), 16'h2000);
      chk($sformatf("hold_in_rdy_c%0d", c), bus.O_IN_RDY, 1'b0);
      chk($sformatf("hold_vld_c%0d", c), bus.O_OUT_VLD, 1'b1);
    end
    bus.I_START = 1'b0;
    collect("hold");
    tick();
    chk("hold_start_ignored", bus.O_BUSY, 1'b0);

    // Reset three beats into a K=8 run, then a fresh accumulate run must see no residue.
    start_run(8, 1'b0);
    for (int b = 0; b < 3; b++) begin
      bus.I_IN_VLD = 1'b1;
      set_beat(1'b0, b, 16'h2000, 16'h2000);
      tick();
    end
    bus.I_IN_VLD = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_in_rdy", bus.O_IN_RDY, 1'b0);
    chk("mid_rst_vld", bus.O_OUT_VLD, 1'b0);
    chk("mid_rst_busy", bus.O_BUSY, 1'b0);
    chk_out_all("mid_rst_out", 16'h0000);
`ifdef SA_SAT_FLAG_EN
    chk("mid_rst_sat", bus.O_SAT_FLAG, 1'b0);
`endif
    full_run("post_rst", '{2, 1'b1, 1'b0, 1'b0, 16'h2000, 16'h2000, 16'h4000, 1'b0});

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
